// File: rtl/uart_tx_if.sv
// Handshake bundle between a byte producer and the UART transmitter.
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] din;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  modport master (
    output tx_start, din,
    input  tx, tx_busy, tx_done_tick
  );

  modport slave (
    input  tx_start, din,
    output tx, tx_busy, tx_done_tick
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter driven by a 16x oversampling baud tick.
// Even parity bit is emitted only when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     s_tick,
  uart_tx_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  localparam logic [4:0] BitLast  = 5'd15;
  localparam logic [4:0] StopLast = 5'(SB_TICK - 1);
  localparam logic [2:0] DataLast = 3'(DBIT - 1);

  state_e     state_q, state_d;
  logic [4:0] s_q, s_d;
  logic [2:0] n_q, n_d;
  logic [7:0] b_q, b_d;
  logic       tx_q, tx_d;
  logic       done_tick;
`ifdef UART_TX_PARITY_EN
  logic       p_q, p_d;
`endif

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    p_d       = p_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.tx_start) begin
          b_d     = bus.din;
          s_d     = 5'd0;
`ifdef UART_TX_PARITY_EN
          p_d     = 1'b0;
`endif
          state_d = StStart;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == BitLast) begin
            s_d     = 5'd0;
            n_d     = 3'd0;
            state_d = StData;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == BitLast) begin
            s_d = 5'd0;
            b_d = b_q >> 1;
`ifdef UART_TX_PARITY_EN
            p_d = p_q ^ b_q[0];
`endif
            if (n_q == DataLast) begin
`ifdef UART_TX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (s_tick) begin
          if (s_q == BitLast) begin
            s_d     = 5'd0;
            state_d = StStop;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      StStop: begin
        if (s_tick) begin
          if (s_q == StopLast) begin
            s_d       = 5'd0;
            done_tick = 1'b1;
            state_d   = StIdle;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level follows the next state so tx changes right at the bit boundary.
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = p_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= 5'd0;
      n_q     <= 3'd0;
      b_q     <= 8'd0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      p_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      p_q     <= p_d;
`endif
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_busy      = (state_q != StIdle);
  assign bus.tx_done_tick = done_tick;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a line monitor decodes frames and checks them against a queue.
module tb_uart_tx;
  localparam int unsigned DBIT = 8;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int unsigned NBITS = 1 + DBIT + PBITS;
  localparam int LIMIT = 2000;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_tick = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   frames = 0;
  int   dones = 0;
  exp_t sb_q[$];

  uart_tx_if bus ();
  uart_tx_if bus32 ();

  uart_tx #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .clk   (clk),
    .reset (reset),
    .s_tick(s_tick),
    .bus   (bus)
  );

  uart_tx #(.DBIT(8), .SB_TICK(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .s_tick(s_tick),
    .bus   (bus32)
  );

  always #5 clk = ~clk;

  // Baud tick on every 4th clock, driven just after the rising edge.
  initial begin : tick_gen
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      s_tick = (cnt == 3);
      cnt = (cnt + 1) % 4;
    end
  end

  // Line monitor: samples each bit at its 8th tick and checks the frame at tx_done_tick.
  bit         mon_active = 0;
  int         tk = 0;
  logic [7:0] got_d;
  logic       got_start, got_par, stop_ok, busy_ok;
  exp_t       e;

  always @(negedge clk) begin
    if (bus.tx_done_tick === 1'b1) dones++;
    if (reset) begin
      mon_active = 0;
    end else begin
      if (!mon_active && bus.tx === 1'b0) begin
        mon_active = 1;
        tk = 0;
        got_d = 8'h00;
        got_start = 1'bx;
        got_par = 1'bx;
        stop_ok = 1'b1;
        busy_ok = 1'b1;
      end
      if (mon_active) begin
        if (bus.tx_busy !== 1'b1) busy_ok = 1'b0;
        if (s_tick) begin
          if (tk % 16 == 7 && tk < int'(NBITS * 16)) begin
            if (tk / 16 == 0) got_start = bus.tx;
            else if (tk / 16 <= int'(DBIT)) got_d[tk/16-1] = bus.tx;
            else got_par = bus.tx;
          end
          if (tk >= int'(NBITS * 16) && bus.tx !== 1'b1) stop_ok = 1'b0;
          if (bus.tx_done_tick === 1'b1) begin
            mon_active = 0;
            frames++;
            n_checks++;
            if (tk != int'(NBITS * 16 + 15))
              $display("FAIL done_timing: tick %0d want %0d", tk, NBITS * 16 + 15);
            else n_pass++;
            n_checks++;
            if (sb_q.size() == 0) begin
              $display("FAIL sb_empty: frame %h seen with no expectation", got_d);
            end else begin
              n_pass++;
              e = sb_q.pop_front();
              n_checks++;
              if (got_start !== 1'b0) $display("FAIL start_bit: got %b want 0", got_start);
              else n_pass++;
              n_checks++;
              if (got_d !== e.data) $display("FAIL frame_data: got %h want %h", got_d, e.data);
              else n_pass++;
`ifdef UART_TX_PARITY_EN
              n_checks++;
              if (got_par !== e.par) $display("FAIL parity_bit: got %b want %b", got_par, e.par);
              else n_pass++;
`endif
            end
            n_checks++;
            if (stop_ok !== 1'b1) $display("FAIL stop_level: got %b want 1", stop_ok);
            else n_pass++;
            n_checks++;
            if (busy_ok !== 1'b1) $display("FAIL busy_span: got %b want 1", busy_ok);
            else n_pass++;
          end
          tk++;
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] d);
    exp_t x;
    x.data = d & 8'((1 << DBIT) - 1);
    x.par  = ^x.data;
    sb_q.push_back(x);
  endtask

  task automatic send(input logic [7:0] d);
    @(posedge clk);
    #2;
    bus.din = d;
    bus.tx_start = 1'b1;
    @(posedge clk);
    #2;
    bus.tx_start = 1'b0;
    bus.din = 8'($urandom);
  endtask

  task automatic wait_done(output bit seen);
    seen = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (bus.tx_done_tick === 1'b1) begin
        seen = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", bus.tx); else n_pass++;
    n_checks++;
    if (bus.tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.tx_busy);
    else n_pass++;
    n_checks++;
    if (bus.tx_done_tick !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.tx_done_tick);
    else n_pass++;
    n_checks++;
    if (bus32.tx !== 1'b1) $display("FAIL reset_tx32: got %b want 1", bus32.tx); else n_pass++;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_single_frame(input logic [7:0] d);
    int d0, f0;
    bit seen;
    d0 = dones;
    f0 = frames;
    push_exp(d);
    send(d);
    @(negedge clk);
    n_checks++;
    if (bus.tx !== 1'b0) $display("FAIL start_tx: got %b want 0", bus.tx); else n_pass++;
    n_checks++;
    if (bus.tx_busy !== 1'b1) $display("FAIL start_busy: got %b want 1", bus.tx_busy);
    else n_pass++;
    wait_done(seen);
    n_checks++;
    if (!seen) $display("FAIL done_seen: got 0 want 1"); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.tx_busy !== 1'b0) $display("FAIL idle_after_done: busy %b want 0", bus.tx_busy);
    else n_pass++;
    repeat (100) @(negedge clk);
    n_checks++;
    if (dones != d0 + 1) $display("FAIL done_once: got %0d want %0d", dones - d0, 1);
    else n_pass++;
    n_checks++;
    if (frames != f0 + 1) $display("FAIL frame_count: got %0d want %0d", frames - f0, 1);
    else n_pass++;
  endtask

  task automatic test_parity();
    logic [7:0] pats[3];
    bit seen;
    pats[0] = 8'h07;
    pats[1] = 8'h00;
    pats[2] = 8'hFE;
    foreach (pats[i]) begin
      push_exp(pats[i]);
      send(pats[i]);
      wait_done(seen);
      n_checks++;
      if (!seen) $display("FAIL parity_done_%0d: got 0 want 1", i); else n_pass++;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int d0, f0;
    bit seen;
    d0 = dones;
    f0 = frames;
    push_exp(8'h5A);
    send(8'h5A);
    repeat (16 * 4 * 3) @(posedge clk);
    #2;
    bus.din = 8'h3C;
    bus.tx_start = 1'b1;
    @(posedge clk);
    #2;
    bus.tx_start = 1'b0;
    wait_done(seen);
    n_checks++;
    if (!seen) $display("FAIL ignore_done: got 0 want 1"); else n_pass++;
    repeat (300) @(negedge clk);
    n_checks++;
    if (bus.tx_busy !== 1'b0) $display("FAIL ignore_busy: got %b want 0", bus.tx_busy);
    else n_pass++;
    n_checks++;
    if (frames != f0 + 1) $display("FAIL ignore_frames: got %0d want 1", frames - f0);
    else n_pass++;
    n_checks++;
    if (dones != d0 + 1) $display("FAIL ignore_dones: got %0d want 1", dones - d0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit seen;
    push_exp(8'h12);
    send(8'h12);
    wait_done(seen);
    n_checks++;
    if (!seen) $display("FAIL b2b_first_done: got 0 want 1"); else n_pass++;
    // Still in STOP during this cycle, so this request must be dropped.
    bus.din = 8'h99;
    bus.tx_start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.tx_busy !== 1'b0) $display("FAIL b2b_ignored: busy %b want 0", bus.tx_busy);
    else n_pass++;
    n_checks++;
    if (bus.tx !== 1'b1) $display("FAIL b2b_idle_tx: got %b want 1", bus.tx); else n_pass++;
    push_exp(8'h55);
    bus.din = 8'h55;
    @(posedge clk);
    #2;
    bus.tx_start = 1'b0;
    bus.din = 8'hC3;
    @(negedge clk);
    n_checks++;
    if (bus.tx !== 1'b0) $display("FAIL b2b_start_tx: got %b want 0", bus.tx); else n_pass++;
    n_checks++;
    if (bus.tx_busy !== 1'b1) $display("FAIL b2b_start_busy: got %b want 1", bus.tx_busy);
    else n_pass++;
    wait_done(seen);
    n_checks++;
    if (!seen) $display("FAIL b2b_second_done: got 0 want 1"); else n_pass++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int d0, f0;
    bit seen;
    d0 = dones;
    f0 = frames;
    push_exp(8'hFF);
    send(8'hFF);
    repeat (16 * 4 * 4 + 32) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    n_checks++;
    if (bus.tx !== 1'b1) $display("FAIL midreset_tx: got %b want 1", bus.tx); else n_pass++;
    n_checks++;
    if (bus.tx_busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", bus.tx_busy);
    else n_pass++;
    repeat (300) @(negedge clk);
    n_checks++;
    if (dones != d0) $display("FAIL midreset_no_done: got %0d want 0", dones - d0);
    else n_pass++;
    n_checks++;
    if (frames != f0) $display("FAIL midreset_frames: got %0d want 0", frames - f0);
    else n_pass++;
    push_exp(8'h81);
    send(8'h81);
    wait_done(seen);
    n_checks++;
    if (!seen) $display("FAIL after_reset_done: got 0 want 1"); else n_pass++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_stop_32();
    bit seen, rise, level_ok;
    int clks, ticks;
    @(posedge clk);
    #2;
    bus32.din = 8'h00;
    bus32.tx_start = 1'b1;
    @(posedge clk);
    #2;
    bus32.tx_start = 1'b0;
    rise = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (bus32.tx === 1'b1) begin
        rise = 1;
        break;
      end
    end
    n_checks++;
    if (!rise) $display("FAIL stop32_rise: got 0 want 1"); else n_pass++;
    clks = 0;
    ticks = 0;
    seen = 0;
    level_ok = 1;
    for (int i = 0; i < LIMIT; i++) begin
      clks++;
      if (s_tick) ticks++;
      if (bus32.tx !== 1'b1) level_ok = 0;
      if (bus32.tx_done_tick === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) $display("FAIL stop32_done: got 0 want 1"); else n_pass++;
    n_checks++;
    if (ticks != 32) $display("FAIL stop32_ticks: got %0d want 32", ticks); else n_pass++;
    n_checks++;
    if (clks != 128) $display("FAIL stop32_clks: got %0d want 128", clks); else n_pass++;
    n_checks++;
    if (!level_ok) $display("FAIL stop32_level: got 0 want 1"); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus32.tx_busy !== 1'b0) $display("FAIL stop32_idle: busy %b want 0", bus32.tx_busy);
    else n_pass++;
  endtask

  initial begin
    bus.tx_start = 1'b0;
    bus.din = 8'h00;
    bus32.tx_start = 1'b0;
    bus32.din = 8'h00;
    test_reset();
    test_single_frame(8'hA5);
    test_parity();
    test_start_ignored();
    test_back_to_back();
    test_reset_midframe();
    test_stop_32();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d want 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
